// File: rtl/slice_scheduler_pkg.sv
// Shared types and default constants for the time-sliced round-robin scheduler.
// Holds the FSM state encoding and the index-width helper used by the arbiter.
package slice_scheduler_pkg;

   localparam int unsigned NUM_REQ_DEF    = 4;
   localparam int unsigned SLICE_SIZE_DEF = 4;
   localparam int unsigned SLICE_MAX_DEF  = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OWN    = 2'd1,
      ST_SWITCH = 2'd2
   } state_e;

   // Index width for a requester vector; a single requester still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? 32'($clog2(n)) : 32'd1;
   endfunction

endpackage : slice_scheduler_pkg

// File: rtl/slice_scheduler_rr_pick.sv
// Combinational round-robin pick: first requesting bit at or after ptr_i,
// searched in circular order. Returns the one-hot choice and its index.
module rr_pick
   import slice_scheduler_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] pick_o,
   output logic [IDX_W-1:0]   pick_idx_o,
   output logic               valid_o
);

   int unsigned      cand;
   logic [IDX_W-1:0] cand_idx;

   // ptr_i is always below NUM_REQ, so a single subtraction wraps the search.
   always_comb begin
      pick_o     = '0;
      pick_idx_o = '0;
      valid_o    = 1'b0;
      cand       = 0;
      cand_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = 32'(ptr_i) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!valid_o && req_i[cand_idx]) begin
            valid_o          = 1'b1;
            pick_o[cand_idx] = 1'b1;
            pick_idx_o       = cand_idx;
         end
      end
   end

endmodule : rr_pick

// File: rtl/slice_scheduler.sv
// Time-sliced round-robin scheduler: one owner holds the resource for at most
// SLICE_MAX cycles, followed by a one-cycle turnaround before re-arbitration.
module slice_scheduler
   import slice_scheduler_pkg::*;
#(
   parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
   parameter int unsigned SLICE_SIZE = SLICE_SIZE_DEF,
   parameter int unsigned SLICE_MAX  = SLICE_MAX_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   output logic [NUM_REQ-1:0]    grant,
   output logic [SLICE_SIZE-1:0] slice_count,
   output logic                  slice_done,
   output logic                  busy
);

   localparam int unsigned IDX_W = idx_width(NUM_REQ);
   localparam logic [SLICE_SIZE-1:0] CNT_LAST = SLICE_SIZE'(SLICE_MAX - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_REQ - 1);

   if ((SLICE_MAX < 1) || (SLICE_MAX > ((2 ** SLICE_SIZE) - 1))) begin : g_bad_slice_max
      $error("slice_scheduler: SLICE_MAX out of range for SLICE_SIZE");
   end

   state_e                state_q, state_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [SLICE_SIZE-1:0] count_q, count_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic [IDX_W-1:0]      owner_q, owner_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;

   logic [NUM_REQ-1:0]    pick;
   logic [IDX_W-1:0]      pick_idx;
   logic                  pick_valid;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req_i      (req),
      .ptr_i      (rr_ptr_q),
      .pick_o     (pick),
      .pick_idx_o (pick_idx),
      .valid_o    (pick_valid)
   );

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         count_q  <= count_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Next-state and next-output logic; outputs default to the idle values.
   always_comb begin
      state_d  = state_q;
      grant_d  = '0;
      count_d  = '0;
      done_d   = 1'b0;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;

      unique case (state_q)
         ST_IDLE, ST_SWITCH: begin
            if (pick_valid) begin
               state_d = ST_OWN;
               grant_d = pick;
               owner_d = pick_idx;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OWN: begin
            // Release and expiry on the same edge collapse into one turnaround.
            if (!req[owner_q] || (count_q == CNT_LAST)) begin
               state_d  = ST_SWITCH;
               done_d   = 1'b1;
               rr_ptr_d = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);
            end else begin
               grant_d = grant_q;
               count_d = count_q + SLICE_SIZE'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = |grant_d;
   end

   assign grant       = grant_q;
   assign slice_count = count_q;
   assign slice_done  = done_q;
   assign busy        = busy_q;

endmodule : slice_scheduler

// File: tb/tb_slice_scheduler.sv
// Bench for slice_scheduler: directed scenarios with literal expectations plus
// randomized requests checked every cycle against a behavioural model.
module tb_slice_scheduler;

   localparam int N     = 4;
   localparam int SMAX  = 10;
   localparam int N1    = 3;
   localparam int SMAX1 = 1;
   localparam int BOUND = (N - 1) * (SMAX + 1) + 1;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] req   = '0;

   logic [3:0] grant;
   logic [3:0] slice_count;
   logic       slice_done;
   logic       busy;

   logic [2:0] grant1;
   logic [1:0] count1;
   logic       done1;
   logic       busy1;

   always #5 clk = ~clk;

   slice_scheduler #(.NUM_REQ(N), .SLICE_SIZE(4), .SLICE_MAX(SMAX)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .grant       (grant),
      .slice_count (slice_count),
      .slice_done  (slice_done),
      .busy        (busy)
   );

   slice_scheduler #(.NUM_REQ(N1), .SLICE_SIZE(2), .SLICE_MAX(SMAX1)) dut1 (
      .clk         (clk),
      .reset       (reset),
      .req         (req[2:0]),
      .grant       (grant1),
      .slice_count (count1),
      .slice_done  (done1),
      .busy        (busy1)
   );

   // Model: who owns the resource, for how long, and where the next search starts.
   typedef struct {
      int owner;
      int count;
      int ptr;
      bit done;
   } model_t;

   model_t     m0, m1;
   bit         chk_en = 1'b0;
   logic [3:0] req_s  = '0;
   logic       rst_s  = 1'b0;
   logic [3:0] g_prev = '0;
   int         wait_c [N];
   int         n_checks = 0;
   int         n_fail   = 0;

   function automatic model_t step(model_t s, logic [3:0] r, logic rst, int n, int smax);
      model_t t;
      bit     found;
      t      = s;
      t.done = 1'b0;
      found  = 1'b0;
      if (!rst) begin
         t.owner = -1;
         t.count = 0;
         t.ptr   = 0;
      end else if (s.owner >= 0) begin
         if (!r[s.owner] || (s.count == smax - 1)) begin
            t.ptr   = (s.owner + 1) % n;
            t.owner = -1;
            t.count = 0;
            t.done  = 1'b1;
         end else begin
            t.count = s.count + 1;
         end
      end else begin
         for (int k = 0; k < n; k++) begin
            int i;
            i = (s.ptr + k) % n;
            if (!found && r[i]) begin
               found   = 1'b1;
               t.owner = i;
               t.count = 0;
            end
         end
      end
      return t;
   endfunction

   always @(posedge clk) begin
      m0    <= step(m0, req, reset, N, SMAX);
      m1    <= step(m1, {1'b0, req[2:0]}, reset, N1, SMAX1);
      req_s <= req;
      rst_s <= reset;
      if (!reset) chk_en <= 1'b1;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both DUTs against the model, plus wait-bound tracking.
   task automatic compare_all();
      if (chk_en) begin
         chk("grant",       grant,       (m0.owner < 0) ? 0 : (1 << m0.owner));
         chk("slice_count", slice_count, m0.count);
         chk("slice_done",  slice_done,  m0.done);
         chk("busy",        busy,        m0.owner >= 0);
         chk("onehot0",     $onehot0(grant), 1);
         chk("busy_or",     busy,        |grant);
         chk("grant1",      grant1,      (m1.owner < 0) ? 0 : (1 << m1.owner));
         chk("count1",      count1,      m1.count);
         chk("done1",       done1,       m1.done);
         chk("busy1",       busy1,       m1.owner >= 0);
         for (int i = 0; i < N; i++) begin
            if (!rst_s || !req_s[i] || g_prev[i]) begin
               wait_c[i] = 0;
            end else begin
               wait_c[i]++;
            end
            if (wait_c[i] > BOUND) begin
               chk("wait_expired", wait_c[i], BOUND);
               wait_c[i] = 0;
            end else if (grant[i] && wait_c[i] > 0) begin
               chk("wait_bound", wait_c[i] <= BOUND, 1);
            end
         end
      end
      g_prev = grant;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         compare_all();
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req   = '0;
      cyc(2);
      chk("rst_grant", grant, 0);
      chk("rst_count", slice_count, 0);
      chk("rst_done",  slice_done, 0);
      chk("rst_busy",  busy, 0);
      reset = 1'b1;
   endtask

   initial begin
      int exp_g [5];
      int dones;
      exp_g = '{1, 2, 4, 8, 1};
      for (int i = 0; i < N; i++) wait_c[i] = 0;

      // Lone persistent requester: 10-cycle slices, pulse at 11, re-grant at 12.
      do_reset();
      req = 4'b0001;
      cyc(1);
      chk("t033_grant", grant, 1);
      chk("t033_count0", slice_count, 0);
      chk("t025_grant1", grant1, 1);
      for (int c = 1; c < 10; c++) begin
         cyc(1);
         chk("t033_count", slice_count, c);
         if (c == 1) begin
            chk("t025_done1", done1, 1);
            chk("t025_gap1",  grant1, 0);
         end
         if (c == 2) chk("t025_regrant1", grant1, 1);
      end
      cyc(1);
      chk("t033_done",  slice_done, 1);
      chk("t033_gap",   grant, 0);
      cyc(1);
      chk("t033_regrant", grant, 1);
      chk("t033_recount", slice_count, 0);

      // All requesting: owners rotate 0,1,2,3,0 with one-cycle gaps.
      do_reset();
      req = 4'b1111;
      for (int c = 1; c <= 45; c++) begin
         cyc(1);
         if (c % 11 == 0) begin
            chk("t034_done", slice_done, 1);
            chk("t034_gap",  grant, 0);
         end else if (c % 11 == 1) begin
            chk("t034_order", grant, exp_g[(c - 1) / 11]);
         end
      end

      // Early release by owner 0 hands over to pending requester 2.
      do_reset();
      req = 4'b0101;
      cyc(4);
      chk("t035_count3", slice_count, 3);
      chk("t035_owner0", grant, 1);
      req = 4'b0100;
      cyc(1);
      chk("t035_done", slice_done, 1);
      chk("t035_gap",  grant, 0);
      cyc(1);
      chk("t035_grant", grant, 4);
      chk("t035_count", slice_count, 0);

      // Release coinciding with expiry yields a single pulse.
      do_reset();
      req = 4'b0001;
      cyc(10);
      chk("t036_count9", slice_count, 9);
      req   = 4'b0000;
      dones = 0;
      for (int c = 0; c < 4; c++) begin
         cyc(1);
         dones += int'(slice_done);
      end
      chk("t036_pulses", dones, 1);

      // Reset mid-slice drops grant silently; arbitration restarts at requester 0's pointer.
      do_reset();
      req = 4'b0011;
      cyc(6);
      chk("t037_count5", slice_count, 5);
      reset = 1'b0;
      cyc(1);
      chk("t037_grant", grant, 0);
      chk("t037_count", slice_count, 0);
      chk("t037_done",  slice_done, 0);
      chk("t037_busy",  busy, 0);
      reset = 1'b1;
      req   = 4'b0010;
      cyc(1);
      chk("t037_regrant", grant, 2);

      // Random requests with mostly persistent bits and rare resets.
      req = 4'($urandom);
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 19) == 0) req[i] = ~req[i];
         end
         reset = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
         cyc(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_slice_scheduler

// File: doc/slice_scheduler.md
SLICE_SCHEDULER -- requirements
Module: slice_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the timed resource.
REQ-002 Parameter SLICE_SIZE, default 4: width of the slice counter.
REQ-003 Parameter SLICE_MAX, default 10: cycles per time slice; legal range 1..2^SLICE_SIZE-1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (reset=0 resets on the next rising clk edge).
REQ-006 req  input  NUM_REQ  per-requester level request; bit i high = requester i wants the resource.
REQ-007 grant  output  NUM_REQ  one-hot (or all-zero) ownership of the resource.
REQ-008 slice_count  output  SLICE_SIZE  cycles the current owner has held the resource, 0-based.
REQ-009 slice_done  output  1  one-cycle pulse when a slice ends, by expiry or release.
REQ-010 busy  output  1  high while any grant bit is high.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, OWN, SWITCH.
REQ-012 IDLE: grant=0 and slice_count=0; if req!=0 at a clk edge, the next state is OWN, with grant set to the first requesting bit at or after rr_ptr in circular order.
REQ-013 OWN: slice_count SHALL increment by 1 each cycle, starting at 0 on the first OWN cycle.
REQ-014 OWN SHALL go to SWITCH when either the owner's req bit is low or slice_count==SLICE_MAX-1 at a clk edge.
REQ-015 If both OWN exit conditions are true on the same edge, the result SHALL be one SWITCH with one slice_done pulse.
REQ-016 slice_done SHALL be high exactly during the single SWITCH cycle.
REQ-017 SWITCH: grant=0 and slice_count=0 for exactly one cycle (turnaround).
REQ-018 On entering SWITCH, rr_ptr SHALL load (owner index + 1) mod NUM_REQ.
REQ-019 SWITCH SHALL exit to OWN when req!=0, with arbitration from the updated rr_ptr per REQ-012; otherwise it SHALL exit to IDLE.
REQ-020 A requester raising req while another owns the resource SHALL wait; no preemption occurs before slice end.
REQ-021 A lone persistent requester SHALL be re-granted after each one-cycle SWITCH gap.
REQ-022 Grant latency from IDLE SHALL be exactly 1 cycle: req sampled at edge k gives grant high after edge k.
REQ-023 Maximum wait for a persistent requester SHALL be (NUM_REQ-1)*(SLICE_MAX+1)+1 cycles.
REQ-024 slice_count SHALL never exceed SLICE_MAX-1; no wrap-around is exposed.
REQ-025 SLICE_MAX=1 SHALL give 1-cycle slices alternating with 1-cycle SWITCH.
REQ-026 grant, slice_count, slice_done and busy SHALL be registered outputs with no combinational path from req.

Reset
REQ-027 While reset=0 at a clk edge: state=IDLE, grant=0, slice_count=0, slice_done=0, busy=0, rr_ptr=0.
REQ-028 Reset mid-OWN SHALL drop grant on the next edge with no slice_done pulse.
REQ-029 Arbitration SHALL resume from rr_ptr=0 on the first edge with reset=1.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE, OWN, SWITCH) and the default parameter constants.
REQ-031 A single sub-module rr_pick SHALL be combinational, taking req and rr_ptr and returning a one-hot choice plus its index.
REQ-032 The FSM, slice counter and rr_ptr register SHALL reside in slice_scheduler.

Verification (NUM_REQ=4, SLICE_MAX=10)
REQ-033 Reset then req=0001 held: grant=0001 after 1 cycle, slice_count 0..9, slice_done at cycle 11, re-grant at cycle 12.
REQ-034 req=1111 held from reset: grant order 0001, 0010, 0100, 1000, 0001, each lasting 10 cycles, separated by 1-cycle gaps.
REQ-035 Owner 0 drops req at slice_count=3 with req=0100 pending: SWITCH next cycle, then grant=0100 with slice_count=0.
REQ-036 Owner drops req on the same edge that slice_count=9: exactly one slice_done pulse.
REQ-037 reset=0 asserted at slice_count=5: all outputs 0 next cycle, no slice_done; after release with req=0010, grant=0010.
REQ-038 Random req over 10k cycles: grant always one-hot-or-zero, busy==|grant, and wait bound of REQ-023 never violated.
